// File: rtl/booth_mult_ctrl.sv
// Booth radix-2 signed multiply sequencer.
// Owns the multiply FSM and the A/Q/M/q_m1 registers. One step is taken per
// RUN cycle, and each step uses an external WIDTH-bit adder that is
// time-shared with other logic. Results are held until the next finish.
module booth_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, q_reg, m_reg;
  logic             q_m1_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic             last_step;
  logic             ext;
  logic [WIDTH-1:0] a_next, q_next;
  logic             q_m1_next;

  // A new operation may only be accepted when no multiply is in flight.
  assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_step = (state_reg == RUN) && (count_reg == LAST);

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A start request that arrives during RUN is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count_reg == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder operand selection from the Booth pair {Q[0], q_m1}.
  // The adder is left at zero when the multiplier is not running.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_reg == RUN) begin
      add_x = a_reg;
      case ({q_reg[0], q_m1_reg})
        2'b01: begin
          add_y   = m_reg;
          add_cin = 1'b0;
        end
        2'b10: begin
          add_y   = ~m_reg;
          add_cin = 1'b1;
        end
        default: begin
          add_y   = '0;
          add_cin = 1'b0;
        end
      endcase
    end
  end

  // Arithmetic right shift of {A,Q,q_m1} after the add.
  // The new top bit is the true sign of the WIDTH+1-bit sum, not the sum
  // MSB. This keeps the result correct when M is the most negative value.
  always_comb begin
    ext       = a_reg[WIDTH-1] ^ add_y[WIDTH-1] ^ add_cout;
    a_next    = {ext, add_sum[WIDTH-1:1]};
    q_next    = {add_sum[0], q_reg[WIDTH-1:1]};
    q_m1_next = q_reg[0];
  end

  // Working registers: load on accept, one Booth step per RUN cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      q_m1_reg  <= 1'b0;
      count_reg <= '0;
    end else if (accept) begin
      a_reg     <= '0;
      q_reg     <= multiplier;
      m_reg     <= multiplicand;
      q_m1_reg  <= 1'b0;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_next;
      q_reg     <= q_next;
      q_m1_reg  <= q_m1_next;
      count_reg <= count_reg + 1'b1;
    end
  end

  // Result capture on the final step. The outputs hold until the next finish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result    <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
    end else if (last_step) begin
      result    <= q_next;
      result_hi <= a_next;
      overflow  <= (a_next != {WIDTH{q_next[WIDTH-1]}});
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl.
// Uses a behavioural adder and a plain signed-multiply reference model.
module tb_booth_mult_ctrl;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             overflow;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  int n_cmp = 0;
  int n_err = 0;

  // Results the DUT should currently be holding.
  logic [WIDTH-1:0] exp_lo  = '0;
  logic [WIDTH-1:0] exp_hi  = '0;
  logic             exp_ovf = 1'b0;

  booth_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_hi    (result_hi),
    .overflow     (overflow),
    .add_x        (add_x),
    .add_y        (add_y),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout)
  );

  // External adder (stands in for cla_32).
  assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference product: full signed product of the two operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return sx * sy;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one multiply.
  // chain=1: the caller is sitting in the DONE cycle, so start is driven
  //          at once (back-to-back).
  // p1/p2:   cycles after the accept edge on which an extra start is
  //          pulsed. These pulses must be ignored.
  task automatic run_op(input logic [31:0] mc, input logic [31:0] mp, input bit chain,
                        input int p1, input int p2, input string tag);
    logic [63:0] p;
    int lat;
    if (!chain) @(negedge clock);
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    check({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
    check({tag, "_done_after_accept"}, 64'(done), 64'd0);
    check({tag, "_held_lo"}, 64'(result), 64'(exp_lo));
    check({tag, "_held_hi"}, 64'(result_hi), 64'(exp_hi));
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      start = ((i == p1) || (i == p2)) ? 1'b1 : 1'b0;
      if (start) begin
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
    end
    start = 1'b0;
    // The accept edge is followed by exactly WIDTH step edges, and done
    // shows right after the last of them.
    check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    p       = ref_prod(mc, mp);
    exp_lo  = p[31:0];
    exp_hi  = p[63:32];
    exp_ovf = (p[63:32] != {32{p[31]}});
    check({tag, "_lo"}, 64'(result), 64'(exp_lo));
    check({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    $display("op %s: %h x %h -> hi=%h lo=%h ovf=%b latency=%0d",
             tag, mc, mp, result_hi, result, overflow, lat);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    check({tag, "_lo_hold"}, 64'(result), 64'(exp_lo));
  endtask

  initial begin
    logic [31:0] specials [6];
    logic [31:0] a, b;
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h0000_0000;
    specials[4] = 32'h0000_0001;
    specials[5] = 32'h0001_0000;

    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(result), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_add_x", 64'(add_x), 64'd0);
    reset = 1'b0;

    // Directed cases.
    run_op(32'd3, 32'd5, 1'b0, 0, 0, "3x5");
    check_idle("3x5");
    run_op(32'hFFFF_FFF9, 32'd6, 1'b0, 0, 0, "m7x6");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0, "minxmin");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, "minxm1");
    run_op(32'd0, 32'h1234_5678, 1'b0, 0, 0, "0xany");

    // start pulses during RUN are ignored; exactly one done must follow.
    run_op(32'd1000, 32'hFFFF_0003, 1'b0, 5, 20, "ignore");
    check_idle("ignore_a");
    check_idle("ignore_b");

    // Back-to-back: a start in the DONE cycle is accepted.
    run_op(32'd9, 32'd9, 1'b0, 0, 0, "pre_b2b");
    run_op(32'd2, 32'd3, 1'b1, 0, 0, "b2b");
    check_idle("b2b");

    // Reset in the middle of RUN aborts the operation immediately.
    @(negedge clock);
    multiplicand = 32'h0000_7777;
    multiplier   = 32'hDEAD_BEEF;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    exp_lo  = '0;
    exp_hi  = '0;
    exp_ovf = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_lo", 64'(result), 64'd0);
    check("midrst_hi", 64'(result_hi), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    $display("op midrst: reset asserted at step 10");
    @(negedge clock);
    reset = 1'b0;
    run_op(32'd4, 32'd4, 1'b0, 0, 0, "4x4_after_rst");

    // Randomized operations, some built from corner values, some chained.
    for (int n = 0; n < 24; n++) begin
      a = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      run_op(a, b, ($urandom_range(0, 1) == 1), 0, 0, "rand");
    end
    check_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
